// File: rtl/can_err_pkg.sv
// Shared types and constants for CAN fault confinement: state encoding,
// counter widths, increment/reload values and error-source indices.
package can_err_pkg;

  typedef enum logic [1:0] {
    ERR_ACTIVE  = 2'd0,
    ERR_PASSIVE = 2'd1,
    BUS_OFF     = 2'd2
  } fc_state_e;

  localparam int TEC_W = 9;
  localparam int REC_W = 8;

  localparam logic [TEC_W-1:0] TEC_ERR_INC = 9'd8;
  localparam logic [REC_W-1:0] REC_ERR_INC = 8'd1;
  localparam logic [REC_W-1:0] REC_RELOAD  = 8'd120;
  localparam logic [REC_W-1:0] REC_MAX     = 8'd255;
  localparam logic [TEC_W-1:0] TEC_BUSOFF  = 9'd256;

  localparam int ERR_SRC_STUFF = 0;
  localparam int ERR_SRC_EOF   = 1;
  localparam int ERR_SRC_CRC   = 2;
  localparam int ERR_SRC_FORM  = 3;

endpackage

// File: rtl/can_busoff_recovery.sv
// Counts runs of 11 recessive sample points while bus-off; done_o is a
// combinational pulse on the sp that completes the RECOVERY_SEQ-th run.
module can_busoff_recovery #(
  parameter int RECOVERY_SEQ = 128
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sp_i,
  input  logic enable_i,
  input  logic rx_bit_i,
  output logic done_o
);

  localparam int SEQ_W = $clog2(RECOVERY_SEQ + 1);

  logic [3:0]       run_q, run_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             run_full;

  assign run_full = sp_i && enable_i && rx_bit_i && (run_q == 4'd10);
  assign done_o   = run_full && (seq_q == SEQ_W'(RECOVERY_SEQ - 1));

  always_comb begin
    run_d = run_q;
    seq_d = seq_q;
    if (!enable_i) begin
      run_d = '0;
      seq_d = '0;
    end else if (sp_i) begin
      if (!rx_bit_i) begin
        run_d = '0;
      end else if (run_full) begin
        run_d = '0;
        seq_d = done_o ? '0 : seq_q + SEQ_W'(1);
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      run_q <= '0;
      seq_q <= '0;
    end else begin
      run_q <= run_d;
      seq_q <= seq_d;
    end
  end

endmodule

// File: rtl/can_fault_confinement.sv
// CAN TEC/REC bookkeeping and fault-confinement state; raises a timed
// error-flag request and recovers from bus-off via can_busoff_recovery.
module can_fault_confinement
  import can_err_pkg::*;
#(
  parameter int N_ERR_SRC     = 4,
  parameter int FLAG_LEN      = 6,
  parameter int WARN_LIMIT    = 96,
  parameter int PASSIVE_LIMIT = 128,
  parameter int RECOVERY_SEQ  = 128
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 sp_i,
  input  logic [N_ERR_SRC-1:0] err_n_i,
  input  logic                 tx_mode_i,
  input  logic                 frame_ok_i,
  input  logic                 rx_bit_i,
  output logic [TEC_W-1:0]     tec_o,
  output logic [REC_W-1:0]     rec_o,
  output logic [1:0]           state_o,
  output logic                 warning_o,
  output logic                 err_flag_o,
  output logic                 err_flag_passive_o,
  output logic [N_ERR_SRC-1:0] err_code_o
);

  localparam logic [TEC_W-1:0] TEC_WARN    = TEC_W'(WARN_LIMIT);
  localparam logic [REC_W-1:0] REC_WARN    = REC_W'(WARN_LIMIT);
  localparam logic [TEC_W-1:0] TEC_PASSIVE = TEC_W'(PASSIVE_LIMIT);
  localparam logic [REC_W-1:0] REC_PASSIVE = REC_W'(PASSIVE_LIMIT);

  fc_state_e            state_q, state_d;
  logic [TEC_W-1:0]     tec_q, tec_d;
  logic [REC_W-1:0]     rec_q, rec_d;
  logic                 warn_q, warn_d;
  logic                 flag_q, flag_d;
  logic                 fpass_q, fpass_d;
  logic [N_ERR_SRC-1:0] code_q, code_d;
  logic [2:0]           fcnt_q, fcnt_d;

  logic [N_ERR_SRC-1:0] err_vec;
  logic                 bus_off, err_evt, ok_evt, rec_done;

  assign err_vec = ~err_n_i;
  assign bus_off = (state_q == BUS_OFF);
  assign err_evt = sp_i && (|err_vec) && !bus_off && !flag_q;
  assign ok_evt  = sp_i && frame_ok_i && !bus_off && !err_evt;

  can_busoff_recovery #(.RECOVERY_SEQ(RECOVERY_SEQ)) u_recovery (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .sp_i     (sp_i),
    .enable_i (bus_off),
    .rx_bit_i (rx_bit_i),
    .done_o   (rec_done)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ERR_ACTIVE;
      tec_q   <= '0;
      rec_q   <= '0;
      warn_q  <= 1'b0;
      flag_q  <= 1'b0;
      fpass_q <= 1'b0;
      code_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tec_q   <= tec_d;
      rec_q   <= rec_d;
      warn_q  <= warn_d;
      flag_q  <= flag_d;
      fpass_q <= fpass_d;
      code_q  <= code_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // State follows the post-update counters so all outputs move together.
  always_comb begin
    state_d = state_q;
    tec_d   = tec_q;
    rec_d   = rec_q;
    flag_d  = flag_q;
    fpass_d = fpass_q;
    code_d  = code_q;
    fcnt_d  = fcnt_q;

    if (err_evt) begin
      if (tx_mode_i)             tec_d = tec_q + TEC_ERR_INC;
      else if (rec_q != REC_MAX) rec_d = rec_q + REC_ERR_INC;
      code_d  = err_vec & (~err_vec + N_ERR_SRC'(1));
      flag_d  = 1'b1;
      fpass_d = (state_q == ERR_PASSIVE);
      fcnt_d  = '0;
    end else if (sp_i && flag_q) begin
      if (fcnt_q == 3'(FLAG_LEN - 1)) begin
        flag_d  = 1'b0;
        fpass_d = 1'b0;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q + 3'd1;
      end
    end

    if (ok_evt) begin
      if (tx_mode_i) begin
        if (tec_q != '0) tec_d = tec_q - TEC_W'(1);
      end else if (rec_q > 8'd127) begin
        rec_d = REC_RELOAD;
      end else if (rec_q != '0) begin
        rec_d = rec_q - REC_W'(1);
      end
    end

    if (bus_off) begin
      if (rec_done) begin
        tec_d   = '0;
        rec_d   = '0;
        state_d = ERR_ACTIVE;
      end
    end else if (tec_d >= TEC_BUSOFF) begin
      tec_d   = TEC_BUSOFF;
      state_d = BUS_OFF;
      flag_d  = 1'b0;
      fpass_d = 1'b0;
      fcnt_d  = '0;
    end else if (tec_d >= TEC_PASSIVE || rec_d >= REC_PASSIVE) begin
      state_d = ERR_PASSIVE;
    end else begin
      state_d = ERR_ACTIVE;
    end

    warn_d = (tec_d >= TEC_WARN) || (rec_d >= REC_WARN);
  end

  always_comb begin
    tec_o              = tec_q;
    rec_o              = rec_q;
    state_o            = state_q;
    warning_o          = warn_q;
    err_flag_o         = flag_q;
    err_flag_passive_o = fpass_q;
    err_code_o         = code_q;
  end

endmodule
